// File: rtl/crypto_pkg.sv
// crypto_pkg: shared mode codes, FSM states and defaults for the crypto scheduler
package crypto_pkg;
    localparam int W_DEF = 16;
    localparam logic [1:0] MODE_ENC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ISSUE, S_WAIT, S_RESP} state_t;
    function automatic logic mode_ok(input logic [1:0] m);
        return m == MODE_ENC || m == MODE_DEC;
    endfunction
endpackage

// File: rtl/crypto_sched_if.sv
// crypto_sched_if: requester-side request/response bus of the crypto scheduler
interface crypto_sched_if
    import crypto_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = W_DEF
);
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_mode;
    logic [W*N_REQ-1:0] req_key;
    logic [W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   resp_valid;
    logic [N_REQ-1:0]   resp_ready;
    logic [W-1:0]       resp_key;
    logic [W-1:0]       resp_data;
    logic               resp_err;
    modport master (
        output req_valid, req_mode, req_key, req_data, resp_ready,
        input  req_ready, resp_valid, resp_key, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_mode, req_key, req_data, resp_ready,
        output req_ready, resp_valid, resp_key, resp_data, resp_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or after ptr, wrapping around
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IW    = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);
    logic [IW-1:0] j;
    // scan from the farthest slot back to ptr so the nearest active slot wins
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N_REQ);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/crypto_sched.sv
// crypto_sched: round-robin scheduler sharing one crypto core between requesters
module crypto_sched
    import crypto_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W       = W_DEF,
    parameter int BGN_CYC = 10,
    parameter int TIMEOUT = 128
) (
    input  logic          clk,
    input  logic          rst,
    crypto_sched_if.slave bus,
    output logic          cc_rst_n,
    output logic [1:0]    cc_mode,
    output logic          cc_bgn,
    output logic [W-1:0]  cc_key,
    output logic [W-1:0]  cc_data,
    input  logic          cc_done,
    input  logic [W-1:0]  cc_key_out,
    input  logic [W-1:0]  cc_data_out,
    output logic          busy
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2((TIMEOUT > BGN_CYC ? TIMEOUT : BGN_CYC) + 1);

    state_t           state;
    logic [IW-1:0]    rr_ptr, a_idx;
    logic [N_REQ-1:0] a_gnt, gnt_q, req_ready_q, resp_valid_q;
    logic             a_any, resp_err_q;
    logic [W-1:0]     resp_key_q, resp_data_q, sel_key, sel_data;
    logic [1:0]       sel_mode;
    logic [CW-1:0]    cnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req(bus.req_valid), .ptr(rr_ptr), .gnt(a_gnt), .idx(a_idx), .any(a_any)
    );

    assign sel_mode       = bus.req_mode[2*a_idx +: 2];
    assign sel_key        = bus.req_key[W*a_idx +: W];
    assign sel_data       = bus.req_data[W*a_idx +: W];
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_key   = resp_key_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    // operation sequencer: arbitrate, reset core, hold bgn, wait for done or timeout, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            gnt_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_key_q   <= '0;
            resp_data_q  <= '0;
            cc_rst_n     <= 1'b1;
            cc_mode      <= '0;
            cc_bgn       <= 1'b0;
            cc_key       <= '0;
            cc_data      <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
        end else begin
            req_ready_q <= '0;
            cnt         <= cnt + 1'b1;
            case (state)
                S_IDLE: if (a_any) begin
                    req_ready_q <= a_gnt;
                    gnt_q       <= a_gnt;
                    rr_ptr      <= IW'((int'(a_idx) + 1) % N_REQ);
                    busy        <= 1'b1;
                    cnt         <= '0;
                    if (mode_ok(sel_mode)) begin
                        state    <= S_PREP;
                        cc_rst_n <= 1'b0;
                        cc_mode  <= sel_mode;
                        cc_key   <= sel_key;
                        cc_data  <= sel_data;
                    end else begin
                        state        <= S_RESP;
                        resp_valid_q <= a_gnt;
                        resp_err_q   <= 1'b1;
                    end
                end
                S_PREP: if (cnt == CW'(1)) begin
                    state    <= S_ISSUE;
                    cc_rst_n <= 1'b1;
                    cc_bgn   <= 1'b1;
                    cnt      <= '0;
                end
                S_ISSUE: if (cnt == CW'(BGN_CYC - 1)) begin
                    state  <= S_WAIT;
                    cc_bgn <= 1'b0;
                    cnt    <= '0;
                end
                S_WAIT: if (cc_done) begin
                    state        <= S_RESP;
                    resp_valid_q <= gnt_q;
                    resp_err_q   <= 1'b0;
                    resp_key_q   <= cc_key_out;
                    resp_data_q  <= cc_data_out;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state        <= S_RESP;
                    resp_valid_q <= gnt_q;
                    resp_err_q   <= 1'b1;
                    resp_key_q   <= '0;
                    resp_data_q  <= '0;
                    cc_rst_n     <= 1'b0;
                end
                S_RESP: begin
                    cc_rst_n <= 1'b1;
                    if (|(bus.resp_ready & gnt_q)) begin
                        state        <= S_IDLE;
                        resp_valid_q <= '0;
                        resp_err_q   <= 1'b0;
                        resp_key_q   <= '0;
                        resp_data_q  <= '0;
                        busy         <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crypto_sched.sv
// tb_crypto_sched: directed and randomized checks of crypto_sched against a behavioural model
module tb_crypto_sched;
    import crypto_pkg::*;
    localparam int N = 2, W = 16, BGN = 10, TO = 128;

    logic         clk = 1'b0, rst = 1'b1;
    logic         cc_rst_n, cc_bgn, busy, cc_done = 1'b0;
    logic [1:0]   cc_mode;
    logic [W-1:0] cc_key, cc_data, cc_key_out = '0, cc_data_out = '0;
    int           checks = 0, failures = 0, m_ptr = 0;
    logic [1:0]   r_mode [N];
    logic [W-1:0] r_key [N], r_data [N];

    crypto_sched_if #(.N_REQ(N), .W(W)) bus ();

    crypto_sched #(.N_REQ(N), .W(W), .BGN_CYC(BGN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cc_rst_n(cc_rst_n), .cc_mode(cc_mode), .cc_bgn(cc_bgn), .cc_key(cc_key), .cc_data(cc_data),
        .cc_done(cc_done), .cc_key_out(cc_key_out), .cc_data_out(cc_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_mode[2*i +: 2] = r_mode[i];
            bus.req_key[W*i +: W]  = r_key[i];
            bus.req_data[W*i +: W] = r_data[i];
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_bus"}, 64'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_key, bus.resp_data}), 64'(0));
        chk({tag, "_core"}, 64'({cc_rst_n, cc_mode, cc_bgn, cc_key, cc_data, busy}), 64'({1'b1, 36'd0}));
    endtask

    // one operation end to end; lat is the WAIT cycle carrying done (negative: core never answers)
    task automatic serve(input int lat, input int hold, input logic [W-1:0] rk_in, input logic [W-1:0] rd_in,
                         output int got);
        int g, er, e;
        logic [N-1:0] v, oh;
        logic [1:0] em;
        logic [W-1:0] ek, ed, rk, rd;
        logic legal, to, ok;
        v = bus.req_valid;
        g = -1;
        for (int i = 0; i < N; i++) if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        if (g < 0) g = 0;
        m_ptr = (g + 1) % N;
        oh = '0;
        oh[g] = 1'b1;
        em = r_mode[g];
        ek = r_key[g];
        ed = r_data[g];
        legal = em == 2'b01 || em == 2'b10;
        to = legal && !(lat >= 0 && lat < TO);
        rk = (legal && !to) ? rk_in : '0;
        rd = (legal && !to) ? rd_in : '0;
        e = 0;
        while (bus.req_ready == '0 && e < 4) begin tick(); e++; end
        chk("req_ready", 64'(bus.req_ready), 64'(oh));
        got = -1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) got = i;
        bus.req_valid[g] = 1'b0;
        r_mode[g] = 2'($urandom);
        r_key[g]  = W'($urandom);
        r_data[g] = W'($urandom);
        drive();
        ok = 1'b1;
        if (legal) begin
            chk("prep_core", 64'({cc_rst_n, cc_bgn, cc_mode, cc_key, cc_data}), 64'({2'b00, em, ek, ed}));
            cc_done = 1'($urandom);
            tick();
            chk("prep2_core", 64'({bus.req_ready, cc_rst_n, cc_bgn, cc_mode, cc_key, cc_data}),
                64'({{N{1'b0}}, 2'b00, em, ek, ed}));
            cc_done = 1'($urandom);
            tick();
            e = 0;
            while (cc_bgn && e < 300) begin
                ok &= cc_rst_n && cc_mode == em && cc_key == ek && cc_data == ed && bus.resp_valid == '0 && bus.req_ready == '0;
                cc_done = 1'($urandom);
                tick();
                e++;
            end
            chk("bgn_cycles", 64'(e), 64'(BGN));
            chk("issue_stable", 64'(ok), 64'(1));
            er = to ? TO : lat + 1;
            ok = 1'b1;
            for (int k = 0; k < er; k++) begin
                ok &= cc_rst_n && !cc_bgn && cc_mode == em && cc_key == ek && cc_data == ed && bus.resp_valid == '0;
                cc_done     = k == lat;
                cc_key_out  = k == lat ? rk_in : W'($urandom);
                cc_data_out = k == lat ? rd_in : W'($urandom);
                tick();
            end
            cc_done = 1'b0;
            chk("wait_stable", 64'(ok), 64'(1));
        end else begin
            e = 0;
            while (bus.resp_valid == '0 && e < 2) begin ok &= !cc_bgn; tick(); e++; end
            chk("illegal_no_bgn", 64'(ok), 64'(1));
        end
        chk("resp_valid", 64'(bus.resp_valid), 64'(oh));
        chk("resp_err", 64'(bus.resp_err), 64'(!legal || to));
        chk("resp_result", 64'({bus.resp_key, bus.resp_data}), 64'({rk, rd}));
        chk("resp_core", 64'({busy, cc_bgn, cc_rst_n}), 64'({2'b10, !to}));
        ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            bus.resp_ready = ~oh & N'($urandom);
            cc_done = 1'($urandom);
            tick();
            ok &= bus.resp_valid == oh && bus.resp_err == (!legal || to) && bus.resp_key == rk &&
                  bus.resp_data == rd && bus.req_ready == '0 && !cc_bgn && cc_rst_n && busy;
        end
        chk("hold_stable", 64'(ok), 64'(1));
        cc_done = 1'b0;
        bus.resp_ready = oh;
        tick();
        bus.resp_ready = '0;
        chk("resp_release", 64'({bus.resp_valid, busy}), 64'(0));
    endtask

    // directed scenarios first, then randomized traffic
    initial begin
        int got, e, pick, lat;
        logic ok;
        bus.req_valid = '0;
        bus.resp_ready = '0;
        for (int i = 0; i < N; i++) begin
            r_mode[i] = '0;
            r_key[i]  = '0;
            r_data[i] = '0;
        end
        drive();
        repeat (2) tick();
        chk_rst("reset");
        rst = 1'b0;
        tick();

        r_mode[0] = MODE_ENC;
        r_key[0]  = 16'h1325;
        r_data[0] = 16'h59B3;
        drive();
        bus.req_valid = 2'b01;
        serve(20, 0, 16'h1234, 16'hABCD, got);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        r_mode[0] = MODE_ENC;
        r_mode[1] = MODE_DEC;
        drive();
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(int'($urandom_range(0, 15)), 0, W'($urandom), W'($urandom), got);
            chk("rr_order", 64'(got), 64'(k % 2));
            if (got >= 0) bus.req_valid[got] = 1'b1;
        end
        bus.req_valid = '0;

        r_mode[1] = MODE_DEC;
        r_key[1]  = 16'hA058;
        r_data[1] = 16'h47E9;
        drive();
        bus.req_valid = 2'b10;
        serve(7, 2, W'($urandom), W'($urandom), got);

        r_mode[0] = 2'b11;
        drive();
        bus.req_valid = 2'b01;
        serve(3, 1, W'($urandom), W'($urandom), got);

        r_mode[0] = MODE_ENC;
        drive();
        bus.req_valid = 2'b01;
        serve(-1, 1, W'($urandom), W'($urandom), got);
        r_mode[1] = MODE_DEC;
        drive();
        bus.req_valid = 2'b10;
        serve(5, 0, W'($urandom), W'($urandom), got);
        r_mode[0] = MODE_DEC;
        drive();
        bus.req_valid = 2'b01;
        serve(TO - 1, 0, W'($urandom), W'($urandom), got);
        r_mode[1] = MODE_ENC;
        drive();
        bus.req_valid = 2'b10;
        serve(0, 0, W'($urandom), W'($urandom), got);

        r_mode[0] = MODE_ENC;
        r_mode[1] = MODE_ENC;
        drive();
        bus.req_valid = 2'b11;
        serve(8, 50, W'($urandom), W'($urandom), got);

        r_mode[0] = MODE_ENC;
        drive();
        bus.req_valid = 2'b01;
        e = 0;
        while (bus.req_ready == '0 && e < 4) begin tick(); e++; end
        bus.req_valid = '0;
        e = 0;
        while (!cc_bgn && e < 4) begin tick(); e++; end
        while (cc_bgn && e < 40) begin tick(); e++; end
        repeat (3) tick();
        chk("wait_busy", 64'({busy, cc_bgn}), 64'(2'b10));
        rst = 1'b1;
        tick();
        chk_rst("mid_reset");
        rst = 1'b0;
        ok = 1'b1;
        repeat (6) begin
            cc_done = 1'($urandom);
            tick();
            ok &= bus.resp_valid == '0 && !busy;
        end
        cc_done = 1'b0;
        chk("no_resp_after_reset", 64'(ok), 64'(1));
        m_ptr = 0;
        r_mode[0] = MODE_DEC;
        r_mode[1] = MODE_ENC;
        drive();
        bus.req_valid = 2'b11;
        serve(4, 0, W'($urandom), W'($urandom), got);
        chk("ptr_after_reset", 64'(got), 64'(0));

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < N; i++) begin
                r_mode[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) : ($urandom_range(0, 1) == 1 ? MODE_ENC : MODE_DEC);
                r_key[i]  = W'($urandom);
                r_data[i] = W'($urandom);
            end
            drive();
            bus.req_valid = N'($urandom_range(1, 2**N - 1));
            pick = int'($urandom_range(0, 19));
            lat = pick == 0 ? -1 : pick == 1 ? TO - 1 : int'($urandom_range(0, 30));
            serve(lat, int'($urandom_range(0, 3)), W'($urandom), W'($urandom), got);
        end

        bus.req_valid = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
